topk_stream_sorter: RTL and testbench

Streaming top-K selector, the parametrised successor to the fixed 4/8/16/32 sorter banks. It accepts one element per cycle on a valid/ready stream and keeps a running descending top-K list in an insertion register array. On the last beat of a frame it transfers the list into a separate output register, so collection of the next frame overlaps with output draining. It sits between the data loader and the downstream consumer in the sorter top.

---
 rtl/topk_stream_sorter_pkg.sv | 23 ++
 rtl/topk_stream_sorter_if.sv | 39 +++
 rtl/topk_insert_slot.sv | 100 ++++++++++
 rtl/topk_stream_sorter.sv | 177 +++++++++++++++++
 tb/tb_topk_stream_sorter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/topk_stream_sorter_pkg.sv
// Shared types, default sizing and the width-generic ordering helper for
// the streaming top-K selector.
package topk_stream_sorter_pkg;

  typedef enum logic {
    IDLE,
    FILL
  } topk_state_e;

  localparam int unsigned TOPK_K       = 8;
  localparam int unsigned TOPK_MAX_LEN = 32;
  // Widest element the compare helper supports; callers extend into this.
  localparam int unsigned TOPK_MAXW    = 64;

  // a >= b; operands must already be sign- or zero-extended to TOPK_MAXW.
  function automatic logic topk_ge(input logic [TOPK_MAXW-1:0] a,
                                   input logic [TOPK_MAXW-1:0] b,
                                   input logic                 sign);
    if (sign) return $signed(a) >= $signed(b);
    return a >= b;
  endfunction

endpackage

// File: rtl/topk_stream_sorter_if.sv
// Input beat stream and result stream of topk_stream_sorter.
// TOPK_INDEX_EN adds the per-slot beat index bus out_idx_o.
interface topk_stream_sorter_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned K         = 8
`ifdef TOPK_INDEX_EN
  , parameter int unsigned IDXW    = 5
`endif
);
  localparam int unsigned CNTW = $clog2(K + 1);

  logic                   sign_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [DATAWIDTH-1:0]   in_data_i;
  logic                   in_last_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [K*DATAWIDTH-1:0] out_data_o;
  logic [CNTW-1:0]        out_count_o;
  logic                   out_trunc_o;
`ifdef TOPK_INDEX_EN
  logic [K*IDXW-1:0]      out_idx_o;

  modport slave (input  sign_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
                 output in_ready_o, out_valid_o, out_data_o, out_count_o,
                        out_trunc_o, out_idx_o);
  modport master (output sign_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
                  input  in_ready_o, out_valid_o, out_data_o, out_count_o,
                         out_trunc_o, out_idx_o);
`else
  modport slave (input  sign_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
                 output in_ready_o, out_valid_o, out_data_o, out_count_o,
                        out_trunc_o);
  modport master (output sign_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
                  input  in_ready_o, out_valid_o, out_data_o, out_count_o,
                         out_trunc_o);
`endif
endinterface

// File: rtl/topk_insert_slot.sv
// One slot of the descending insertion array: holds, takes the new element,
// or takes its predecessor's contents. TOPK_INDEX_EN adds a beat index.
module topk_insert_slot
  import topk_stream_sorter_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8
`ifdef TOPK_INDEX_EN
  , parameter int unsigned IDXW    = 5
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 sign_i,
  input  logic                 ins_i,
  input  logic                 clr_i,
  input  logic                 take_new_i,
  input  logic [DATAWIDTH-1:0] new_val_i,
  input  logic [DATAWIDTH-1:0] prev_val_i,
  input  logic                 prev_valid_i,
`ifdef TOPK_INDEX_EN
  input  logic [IDXW-1:0]      new_idx_i,
  input  logic [IDXW-1:0]      prev_idx_i,
  output logic [IDXW-1:0]      idx_o,
  output logic [IDXW-1:0]      idx_nx_o,
`endif
  output logic [DATAWIDTH-1:0] val_o,
  output logic                 valid_o,
  output logic                 ge_o,
  output logic [DATAWIDTH-1:0] val_nx_o,
  output logic                 valid_nx_o
);
  logic [DATAWIDTH-1:0] val_q, val_d;
  logic                 valid_q, valid_d, valid_nx;
`ifdef TOPK_INDEX_EN
  logic [IDXW-1:0]      idx_q, idx_d;
`endif

  function automatic logic [TOPK_MAXW-1:0] ext(input logic [DATAWIDTH-1:0] v,
                                               input logic                 s);
    logic [TOPK_MAXW-1:0] r;
    r = TOPK_MAXW'(v);
    for (int unsigned b = DATAWIDTH; b < TOPK_MAXW; b++) r[b] = s & v[DATAWIDTH-1];
    return r;
  endfunction

  // A valid slot holding a value >= the newcomer stays put (stable ties).
  assign ge_o = valid_q && topk_ge(ext(val_q, sign_i), ext(new_val_i, sign_i), sign_i);

  // Next contents after an insertion; a close clears valid but not the data.
  always_comb begin
    val_d    = val_q;
    valid_nx = valid_q;
`ifdef TOPK_INDEX_EN
    idx_d    = idx_q;
`endif
    if (ins_i && !ge_o) begin
      if (take_new_i) begin
        val_d    = new_val_i;
        valid_nx = 1'b1;
`ifdef TOPK_INDEX_EN
        idx_d    = new_idx_i;
`endif
      end else begin
        val_d    = prev_val_i;
        valid_nx = prev_valid_i;
`ifdef TOPK_INDEX_EN
        idx_d    = prev_idx_i;
`endif
      end
    end
    valid_d = valid_nx && !clr_i;
  end

  // Slot storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q   <= '0;
      valid_q <= 1'b0;
`ifdef TOPK_INDEX_EN
      idx_q   <= '0;
`endif
    end else begin
      val_q   <= val_d;
      valid_q <= valid_d;
`ifdef TOPK_INDEX_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign val_o      = val_q;
  assign valid_o    = valid_q;
  assign val_nx_o   = val_d;
  assign valid_nx_o = valid_nx;
`ifdef TOPK_INDEX_EN
  assign idx_o      = idx_q;
  assign idx_nx_o   = idx_d;
`endif

endmodule

// File: rtl/topk_stream_sorter.sv
// Streaming top-K selector: inserts one element per beat into a descending
// slot array and hands the list to a separate output register on frame close.
// Optional macro TOPK_INDEX_EN adds per-slot beat indices (out_idx_o).
module topk_stream_sorter
  import topk_stream_sorter_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned K         = TOPK_K,
  parameter int unsigned MAX_LEN   = TOPK_MAX_LEN
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  topk_stream_sorter_if.slave  bus
);
  localparam int unsigned IDXW = $clog2(MAX_LEN);
  localparam int unsigned CNTW = $clog2(K + 1);

  topk_state_e          state_q, state_d;
  logic                 sign_q, sign_d, sign_eff;
  logic [IDXW-1:0]      beat_q, beat_d, cur_idx;
  logic                 accept, close, trunc;

  logic [DATAWIDTH-1:0] val_q [K];
  logic [DATAWIDTH-1:0] val_nx [K];
  logic [DATAWIDTH-1:0] prev_val [K];
  logic                 valid_q [K];
  logic                 valid_nx [K];
  logic                 prev_valid [K];
  logic                 ge [K];
  logic                 take_new [K];
`ifdef TOPK_INDEX_EN
  logic [IDXW-1:0]      idx_q [K];
  logic [IDXW-1:0]      idx_nx [K];
  logic [IDXW-1:0]      prev_idx [K];
  logic [K*IDXW-1:0]    out_idx_q, out_idx_d;
`endif

  logic                 out_valid_q, out_valid_d;
  logic [K*DATAWIDTH-1:0] out_data_q, out_data_d;
  logic [CNTW-1:0]      out_count_q, out_count_d;
  logic                 out_trunc_q, out_trunc_d;

  assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;

  // Frame control: acceptance, close detection and FSM next state.
  always_comb begin
    accept   = bus.in_valid_i && bus.in_ready_o;
    cur_idx  = (state_q == IDLE) ? '0 : beat_q;
    sign_eff = (state_q == IDLE) ? bus.sign_i : sign_q;
    trunc    = accept && !bus.in_last_i && (cur_idx == IDXW'(MAX_LEN - 1));
    close    = accept && (bus.in_last_i || trunc);
    state_d  = state_q;
    sign_d   = sign_q;
    beat_d   = beat_q;
    if (accept) begin
      if (state_q == IDLE) sign_d = bus.sign_i;
      beat_d  = cur_idx + 1'b1;
      state_d = close ? IDLE : FILL;
    end
  end

  // FSM and frame bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      beat_q  <= beat_d;
    end
  end

  // Chain wiring: slot i loads new if slot i-1 kept its place, else shifts.
  always_comb begin
    take_new[0]   = 1'b1;
    prev_val[0]   = bus.in_data_i;
    prev_valid[0] = 1'b0;
`ifdef TOPK_INDEX_EN
    prev_idx[0]   = cur_idx;
`endif
    for (int unsigned i = 1; i < K; i++) begin
      take_new[i]   = ge[i-1];
      prev_val[i]   = val_q[i-1];
      prev_valid[i] = valid_q[i-1];
`ifdef TOPK_INDEX_EN
      prev_idx[i]   = idx_q[i-1];
`endif
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_slot
    topk_insert_slot #(
      .DATAWIDTH (DATAWIDTH)
`ifdef TOPK_INDEX_EN
      , .IDXW    (IDXW)
`endif
    ) u_slot (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .sign_i       (sign_eff),
      .ins_i        (accept),
      .clr_i        (close),
      .take_new_i   (take_new[i]),
      .new_val_i    (bus.in_data_i),
      .prev_val_i   (prev_val[i]),
      .prev_valid_i (prev_valid[i]),
`ifdef TOPK_INDEX_EN
      .new_idx_i    (cur_idx),
      .prev_idx_i   (prev_idx[i]),
      .idx_o        (idx_q[i]),
      .idx_nx_o     (idx_nx[i]),
`endif
      .val_o        (val_q[i]),
      .valid_o      (valid_q[i]),
      .ge_o         (ge[i]),
      .val_nx_o     (val_nx[i]),
      .valid_nx_o   (valid_nx[i])
    );
  end

  // Output register: loads the post-insert array on close, empties on drain.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
`ifdef TOPK_INDEX_EN
    out_idx_d   = out_idx_q;
`endif
    if (close) begin
      out_valid_d = 1'b1;
      out_trunc_d = trunc;
      out_count_d = '0;
      for (int unsigned i = 0; i < K; i++) begin
        out_data_d[i*DATAWIDTH +: DATAWIDTH] = valid_nx[i] ? val_nx[i] : '0;
`ifdef TOPK_INDEX_EN
        out_idx_d[i*IDXW +: IDXW] = valid_nx[i] ? idx_nx[i] : '0;
`endif
        out_count_d = out_count_d + CNTW'(valid_nx[i]);
      end
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Result holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
`ifdef TOPK_INDEX_EN
      out_idx_q   <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
`ifdef TOPK_INDEX_EN
      out_idx_q   <= out_idx_d;
`endif
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.out_count_o = out_count_q;
  assign bus.out_trunc_o = out_trunc_q;
`ifdef TOPK_INDEX_EN
  assign bus.out_idx_o   = out_idx_q;
`endif

endmodule

// File: tb/tb_topk_stream_sorter.sv
// Bench for topk_stream_sorter (K=4, MAX_LEN=32): directed frames with literal
// expectations plus a frame-level model (stable sort, keep top K) checked every cycle.
module tb_topk_stream_sorter;
  localparam int unsigned DW      = 8;
  localparam int unsigned K       = 4;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned IDXW    = $clog2(MAX_LEN);

  logic clk, rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

`ifdef TOPK_INDEX_EN
  topk_stream_sorter_if #(.DATAWIDTH(DW), .K(K), .IDXW(IDXW)) bus ();
`else
  topk_stream_sorter_if #(.DATAWIDTH(DW), .K(K)) bus ();
`endif

  topk_stream_sorter #(.DATAWIDTH(DW), .K(K), .MAX_LEN(MAX_LEN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef struct { logic [DW-1:0] v; int unsigned idx; } beat_t;
  typedef struct {
    logic [K*DW-1:0]   data;
    logic [K*IDXW-1:0] idx;
    int unsigned       count;
    logic              trunc;
  } res_t;

  beat_t frame[$];
  logic  frame_sign;
  res_t  exp_q[$];

  function automatic logic gt(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
    if (s) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Repeated selection of the first strictly-largest remaining beat.
  function automatic res_t build(input logic tr);
    res_t r;
    bit   picked [MAX_LEN];
    int   best;
    for (int i = 0; i < int'(MAX_LEN); i++) picked[i] = 1'b0;
    r.data  = '0;
    r.idx   = '0;
    r.trunc = tr;
    r.count = (frame.size() < K) ? frame.size() : K;
    for (int unsigned j = 0; j < r.count; j++) begin
      best = -1;
      for (int i = 0; i < frame.size(); i++)
        if (!picked[i] && (best < 0 || gt(frame[i].v, frame[best].v, frame_sign))) best = i;
      picked[best] = 1'b1;
      r.data[j*DW +: DW]     = frame[best].v;
      r.idx[j*IDXW +: IDXW]  = IDXW'(frame[best].idx);
    end
    return r;
  endfunction

  // Compare state produced by the last edge, then advance the model by the
  // handshakes the upcoming edge will perform (inputs are stable here).
  always @(negedge clk) begin
    logic exp_valid, acc, last;
    beat_t b;
    if (!rst_n) begin
      frame.delete();
      exp_q.delete();
      chk("rst_out_valid", bus.out_valid_o, 1'b0);
    end else begin
      exp_valid = (exp_q.size() != 0);
      chk("out_valid", bus.out_valid_o, exp_valid);
      chk("in_ready", bus.in_ready_o, !exp_valid || bus.out_ready_i);
      if (exp_valid) begin
        chk("out_data", bus.out_data_o, exp_q[0].data);
        chk("out_count", bus.out_count_o, exp_q[0].count);
        chk("out_trunc", bus.out_trunc_o, exp_q[0].trunc);
`ifdef TOPK_INDEX_EN
        chk("out_idx", bus.out_idx_o, exp_q[0].idx);
`endif
      end
      acc = bus.in_valid_i && (!exp_valid || bus.out_ready_i);
      if (exp_valid && bus.out_ready_i) void'(exp_q.pop_front());
      if (acc) begin
        if (frame.size() == 0) frame_sign = bus.sign_i;
        b.v   = bus.in_data_i;
        b.idx = frame.size();
        frame.push_back(b);
        last = bus.in_last_i;
        if (last || frame.size() == MAX_LEN) begin
          exp_q.push_back(build(!last));
          frame.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] v, input logic last, input logic s);
    int unsigned n = 0;
    bit acc = 1'b0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = v;
    bus.in_last_i  = last;
    bus.sign_i     = s;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 50) begin
        chk("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
    bus.in_valid_i = 1'b0;
    bus.in_last_i  = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    int unsigned len;
    logic s;
    rst_n          = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.in_last_i  = 1'b0;
    bus.sign_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    #12;
    chk("reset_valid", bus.out_valid_o, 1'b0);
    chk("reset_ready", bus.in_ready_o, 1'b1);
    chk("reset_data", bus.out_data_o, 32'h0);
    chk("reset_count", bus.out_count_o, 0);
    chk("reset_trunc", bus.out_trunc_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Unsigned 3,9,1,7,5: slot0..3 = 9,7,5,3, visible right after the last edge.
    send(8'd3, 0, 0); send(8'd9, 0, 0); send(8'd1, 0, 0); send(8'd7, 0, 0); send(8'd5, 1, 0);
    chk("a_valid", bus.out_valid_o, 1'b1);
    chk("a_data", bus.out_data_o, 32'h03050709);
    chk("a_count", bus.out_count_o, 4);
    chk("a_trunc", bus.out_trunc_o, 1'b0);
    drain();

    // Signed: 7F,01,FF,80 ; unsigned: FF,80,7F,01.
    send(8'h80, 0, 1); send(8'h7F, 0, 1); send(8'hFF, 0, 1); send(8'h01, 1, 1);
    chk("signed_data", bus.out_data_o, 32'h80FF017F);
    drain();
    send(8'h80, 0, 0); send(8'h7F, 0, 0); send(8'hFF, 0, 0); send(8'h01, 1, 0);
    chk("unsigned_data", bus.out_data_o, 32'h017F80FF);
    drain();

    // Short frame: empty slots read zero.
    send(8'd5, 0, 0); send(8'd2, 1, 0);
    chk("short_data", bus.out_data_o, 32'h00000205);
    chk("short_count", bus.out_count_o, 2);
    drain();

    // Ties keep arrival order.
    send(8'd7, 0, 0); send(8'd7, 0, 0); send(8'd3, 1, 0);
    chk("tie_data", bus.out_data_o, 32'h00030707);
`ifdef TOPK_INDEX_EN
    chk("tie_idx", bus.out_idx_o, 20'h00820);
`endif
    drain();

    // Backpressure: pending result stalls input; then swap in one edge.
    send(8'd1, 0, 0); send(8'd2, 1, 0);
    bus.in_valid_i = 1'b1; bus.in_data_i = 8'd9; bus.in_last_i = 1'b1; bus.sign_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready_o, 1'b0);
      chk("bp_hold", bus.out_data_o, 32'h00000102);
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0; bus.in_valid_i = 1'b0; bus.in_last_i = 1'b0;
    chk("swap_valid", bus.out_valid_o, 1'b1);
    chk("swap_data", bus.out_data_o, 32'h00000009);
    drain();

    // Forced close at MAX_LEN, then a normal frame from the leftover beats.
    for (int unsigned i = 1; i <= 32; i++) send(8'((i * 37 + 11) % 256), 0, 0);
    chk("trunc_valid", bus.out_valid_o, 1'b1);
    chk("trunc_flag", bus.out_trunc_o, 1'b1);
    chk("trunc_count", bus.out_count_o, 4);
    drain();
    for (int unsigned i = 33; i <= 40; i++) send(8'((i * 37 + 11) % 256), i == 40, 0);
    chk("post_trunc_flag", bus.out_trunc_o, 1'b0);
    chk("post_trunc_count", bus.out_count_o, 4);
    drain();

    // Reset mid-frame discards it.
    send(8'd50, 0, 0); send(8'd60, 0, 0); send(8'd70, 0, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_out", bus.out_valid_o, 1'b0);
    send(8'h10, 0, 0); send(8'h20, 1, 0);
    chk("rst_next_data", bus.out_data_o, 32'h00001020);
    chk("rst_next_count", bus.out_count_o, 2);
`ifdef TOPK_INDEX_EN
    chk("rst_next_idx", bus.out_idx_o, 20'h00001);
`endif
    drain();

    // Back-to-back frames with continuous draining; values chosen to tie.
    bus.out_ready_i = 1'b1;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 9);
      s   = 1'($urandom_range(0, 1));
      for (int unsigned b = 0; b < len; b++) begin
        v = 8'($urandom_range(0, 255)) & 8'hC3;
        send(v, b == len - 1, s);
      end
    end
    repeat (3) @(posedge clk);
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
